// File: rtl/lsu_mem_aligner.sv
// ---------------------------------------------------------------------------
// lsu_mem_aligner
//
// Purpose:
//   Aligns core load/store traffic onto a word-wide, little-endian data
//   memory port.
//   - Stores: the byte address and access size become a word-aligned request.
//     The request carries a byte-lane mask and write data shifted into the
//     addressed lanes. Unmasked lanes are driven to zero.
//   - Loads: the lane offset, size and signedness of every accepted load are
//     queued in a small in-order load queue (LDQ). Each returned memory word
//     pops one entry. The entry selects the lane to extract and the extension
//     to apply.
//   The request stage and the response stage are both registered.
//
// Configuration macro:
//   LSU_ALIGNER_ALIGN_FAULT_EN
//     defined   : a misaligned access is dropped (no memory request, no LDQ
//                 push) and oCORE_FAULT pulses one cycle after the accept.
//     undefined : the low address bits are forced to alignment. The half
//                 access clears a[0] and the word access clears a[1:0]. The
//                 access is issued normally and oCORE_FAULT is tied to 0.
//
// Parameters:
//   LDQ_DEPTH    maximum outstanding loads (power of 2, >= 2)
//   LDQ_DEPTH_N  log2(LDQ_DEPTH)
//
// Ports:
//   iCLOCK       clock
//   iRESET       asynchronous reset, active-high
//   iRESET_SYNC  synchronous clear, active-high (same effect as iRESET)
//   iCORE_REQ    core request valid
//   oCORE_BUSY   request not accepted this cycle (combinational)
//   iCORE_RW     0 = load, 1 = store
//   iCORE_ORDER  0 = byte, 1 = half, 2/3 = word
//   iCORE_SIGNED sign-extend enable for loads
//   iCORE_ADDR   byte address
//   iCORE_DATA   store data, right-justified
//   oCORE_VALID  load data valid (1-cycle pulse)
//   oCORE_DATA   extracted / extended load data
//   oCORE_FAULT  misaligned-access pulse
//   oMEM_REQ     memory request valid
//   iMEM_BUSY    memory stall; oMEM_* are held while it is high
//   oMEM_RW      0 = load, 1 = store
//   oMEM_ADDR    word-aligned address
//   oMEM_MASK    byte-lane mask (bit k = byte lane k)
//   oMEM_DATA    lane-shifted store data
//   iMEM_VALID   load data return
//   iMEM_DATA    returned word
// ---------------------------------------------------------------------------
module lsu_mem_aligner #(
    parameter int LDQ_DEPTH   = 4,
    parameter int LDQ_DEPTH_N = 2
) (
    input  logic        iCLOCK,
    input  logic        iRESET,
    input  logic        iRESET_SYNC,
    input  logic        iCORE_REQ,
    output logic        oCORE_BUSY,
    input  logic        iCORE_RW,
    input  logic [1:0]  iCORE_ORDER,
    input  logic        iCORE_SIGNED,
    input  logic [31:0] iCORE_ADDR,
    input  logic [31:0] iCORE_DATA,
    output logic        oCORE_VALID,
    output logic [31:0] oCORE_DATA,
    output logic        oCORE_FAULT,
    output logic        oMEM_REQ,
    input  logic        iMEM_BUSY,
    output logic        oMEM_RW,
    output logic [31:0] oMEM_ADDR,
    output logic [3:0]  oMEM_MASK,
    output logic [31:0] oMEM_DATA,
    input  logic        iMEM_VALID,
    input  logic [31:0] iMEM_DATA
);

    // One queued load: lane offset, access size, sign-extend flag.
    typedef struct packed {
        logic [1:0] off;
        logic [1:0] order;
        logic       sgn;
    } ldq_entry_t;

    localparam logic [LDQ_DEPTH_N:0] LDQ_FULL_COUNT = (LDQ_DEPTH_N+1)'(LDQ_DEPTH);

    // -----------------------------------------------------------------------
    // Request decode
    // -----------------------------------------------------------------------
    logic       is_byte;
    logic       is_half;
    logic       is_word;
    logic [1:0] eff_off;
    logic       fault_cond;
    logic       ldq_full;
    logic       accept;
    logic       issue;
    logic       push;
    logic       pop;

    assign is_byte = (iCORE_ORDER == 2'd0);
    assign is_half = (iCORE_ORDER == 2'd1);
    assign is_word = iCORE_ORDER[1];

`ifdef LSU_ALIGNER_ALIGN_FAULT_EN
    logic misaligned;
    assign misaligned = (is_half && iCORE_ADDR[0]) ||
                        (is_word && (iCORE_ADDR[1:0] != 2'b00));
    assign fault_cond = misaligned;
    // Misaligned accesses are never issued, so the raw offset is always legal
    // for whatever reaches the memory port or the LDQ.
    assign eff_off    = iCORE_ADDR[1:0];
`else
    assign fault_cond = 1'b0;
    // Drop the low address bits that the access size cannot use.
    assign eff_off    = is_word ? 2'b00 :
                        is_half ? {iCORE_ADDR[1], 1'b0} :
                                  iCORE_ADDR[1:0];
`endif

    logic                   mem_req_reg;
    logic [LDQ_DEPTH_N:0]   ldq_count_reg;

    assign ldq_full   = (ldq_count_reg == LDQ_FULL_COUNT);
    // A load is refused whenever the LDQ is full, even if it would fault.
    // The fault is still reported once a slot frees up.
    assign oCORE_BUSY = (mem_req_reg && iMEM_BUSY) || (!iCORE_RW && ldq_full);
    assign accept     = iCORE_REQ && !oCORE_BUSY;
    assign issue      = accept && !fault_cond;
    assign push       = issue && !iCORE_RW;
    assign pop        = iMEM_VALID && (ldq_count_reg != '0);

    // -----------------------------------------------------------------------
    // Per-lane mask and store data
    // -----------------------------------------------------------------------
    logic [3:0]  lane_mask;
    logic [31:0] lane_data;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            // A byte occupies its own lane. A half occupies the lane pair
            // picked by a[1]. A word occupies every lane.
            assign lane_mask[gi] = is_word ||
                                   (is_half ? (LANE[1] == eff_off[1]) :
                                              (LANE == eff_off));
            // Byte data is replicated to every lane and the mask selects one
            // copy. Half data alternates low/high bytes across each lane pair.
            assign lane_data[8*gi +: 8] =
                !lane_mask[gi] ? 8'h00 :
                is_byte        ? iCORE_DATA[7:0] :
                is_half        ? iCORE_DATA[8*(gi % 2) +: 8] :
                                 iCORE_DATA[8*gi +: 8];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Request stage
    // -----------------------------------------------------------------------
    logic        mem_req_next;
    logic        mem_rw_reg,   mem_rw_next;
    logic [31:0] mem_addr_reg, mem_addr_next;
    logic [3:0]  mem_mask_reg, mem_mask_next;
    logic [31:0] mem_data_reg, mem_data_next;
    logic        fault_reg,    fault_next;

    always_comb begin
        mem_req_next  = mem_req_reg;
        mem_rw_next   = mem_rw_reg;
        mem_addr_next = mem_addr_reg;
        mem_mask_next = mem_mask_reg;
        mem_data_next = mem_data_reg;
        fault_next    = accept && fault_cond;
        if (issue) begin
            mem_req_next  = 1'b1;
            mem_rw_next   = iCORE_RW;
            mem_addr_next = {iCORE_ADDR[31:2], 2'b00};
            mem_mask_next = lane_mask;
            mem_data_next = lane_data;
        end else if (accept || !iMEM_BUSY) begin
            // Either the current request was taken by memory, or a faulting
            // accept replaced it. An accept is only possible when no request
            // is stalled.
            mem_req_next = 1'b0;
        end
    end

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            mem_req_reg  <= 1'b0;
            mem_rw_reg   <= 1'b0;
            mem_addr_reg <= '0;
            mem_mask_reg <= '0;
            mem_data_reg <= '0;
            fault_reg    <= 1'b0;
        end else if (iRESET_SYNC) begin
            mem_req_reg  <= 1'b0;
            mem_rw_reg   <= 1'b0;
            mem_addr_reg <= '0;
            mem_mask_reg <= '0;
            mem_data_reg <= '0;
            fault_reg    <= 1'b0;
        end else begin
            mem_req_reg  <= mem_req_next;
            mem_rw_reg   <= mem_rw_next;
            mem_addr_reg <= mem_addr_next;
            mem_mask_reg <= mem_mask_next;
            mem_data_reg <= mem_data_next;
            fault_reg    <= fault_next;
        end
    end

    assign oMEM_REQ  = mem_req_reg;
    assign oMEM_RW   = mem_rw_reg;
    assign oMEM_ADDR = mem_addr_reg;
    assign oMEM_MASK = mem_mask_reg;
    assign oMEM_DATA = mem_data_reg;

`ifdef LSU_ALIGNER_ALIGN_FAULT_EN
    assign oCORE_FAULT = fault_reg;
`else
    assign oCORE_FAULT = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Load queue
    // -----------------------------------------------------------------------
    ldq_entry_t             ldq_mem_reg [LDQ_DEPTH];
    ldq_entry_t             push_entry;
    logic [LDQ_DEPTH_N-1:0] wr_ptr_reg, wr_ptr_next;
    logic [LDQ_DEPTH_N-1:0] rd_ptr_reg, rd_ptr_next;
    logic [LDQ_DEPTH_N:0]   ldq_count_next;

    assign push_entry = '{off: eff_off, order: iCORE_ORDER, sgn: iCORE_SIGNED};

    // The storage holds only data. The pointers and count define which
    // entries are live, so the storage needs no reset.
    always_ff @(posedge iCLOCK) begin
        if (push) begin
            ldq_mem_reg[wr_ptr_reg] <= push_entry;
        end
    end

    always_comb begin
        // Pointers wrap naturally because LDQ_DEPTH is a power of two.
        wr_ptr_next    = push ? wr_ptr_reg + 1'b1 : wr_ptr_reg;
        rd_ptr_next    = pop  ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
        ldq_count_next = ldq_count_reg;
        case ({push, pop})
            2'b10:   ldq_count_next = ldq_count_reg + 1'b1;
            2'b01:   ldq_count_next = ldq_count_reg - 1'b1;
            default: ldq_count_next = ldq_count_reg;
        endcase
    end

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            ldq_count_reg <= '0;
        end else if (iRESET_SYNC) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            ldq_count_reg <= '0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            ldq_count_reg <= ldq_count_next;
        end
    end

    // -----------------------------------------------------------------------
    // Response stage: extract the addressed lane and extend it
    // -----------------------------------------------------------------------
    ldq_entry_t  head_entry;
    logic [31:0] ret_shifted;
    logic [31:0] core_data_next;
    logic        core_data_reg;
    logic [31:0] core_word_reg;

    always_comb begin
        head_entry     = ldq_mem_reg[rd_ptr_reg];
        ret_shifted    = iMEM_DATA >> {head_entry.off, 3'b000};
        core_data_next = iMEM_DATA;
        case (head_entry.order)
            2'd0: core_data_next = {{24{head_entry.sgn & ret_shifted[7]}},
                                    ret_shifted[7:0]};
            2'd1: core_data_next = {{16{head_entry.sgn & ret_shifted[15]}},
                                    ret_shifted[15:0]};
            default: core_data_next = iMEM_DATA;
        endcase
    end

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            core_data_reg <= 1'b0;
            core_word_reg <= '0;
        end else if (iRESET_SYNC) begin
            core_data_reg <= 1'b0;
            core_word_reg <= '0;
        end else begin
            core_data_reg <= pop;
            if (pop) begin
                core_word_reg <= core_data_next;
            end
        end
    end

    assign oCORE_VALID = core_data_reg;
    assign oCORE_DATA  = core_word_reg;

endmodule

// File: tb/tb_lsu_mem_aligner.sv
// ---------------------------------------------------------------------------
// tb_lsu_mem_aligner
//
// Directed testbench for lsu_mem_aligner. Inputs change 1 time unit after
// each rising edge, and the registered outputs are sampled at the same
// point. Each check prints one line.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lsu_mem_aligner;

    logic        iCLOCK;
    logic        iRESET;
    logic        iRESET_SYNC;
    logic        iCORE_REQ;
    logic        oCORE_BUSY;
    logic        iCORE_RW;
    logic [1:0]  iCORE_ORDER;
    logic        iCORE_SIGNED;
    logic [31:0] iCORE_ADDR;
    logic [31:0] iCORE_DATA;
    logic        oCORE_VALID;
    logic [31:0] oCORE_DATA;
    logic        oCORE_FAULT;
    logic        oMEM_REQ;
    logic        iMEM_BUSY;
    logic        oMEM_RW;
    logic [31:0] oMEM_ADDR;
    logic [3:0]  oMEM_MASK;
    logic [31:0] oMEM_DATA;
    logic        iMEM_VALID;
    logic [31:0] iMEM_DATA;

    int checks_cnt;
    int errors_cnt;

    lsu_mem_aligner #(
        .LDQ_DEPTH   (4),
        .LDQ_DEPTH_N (2)
    ) dut (
        .iCLOCK       (iCLOCK),
        .iRESET       (iRESET),
        .iRESET_SYNC  (iRESET_SYNC),
        .iCORE_REQ    (iCORE_REQ),
        .oCORE_BUSY   (oCORE_BUSY),
        .iCORE_RW     (iCORE_RW),
        .iCORE_ORDER  (iCORE_ORDER),
        .iCORE_SIGNED (iCORE_SIGNED),
        .iCORE_ADDR   (iCORE_ADDR),
        .iCORE_DATA   (iCORE_DATA),
        .oCORE_VALID  (oCORE_VALID),
        .oCORE_DATA   (oCORE_DATA),
        .oCORE_FAULT  (oCORE_FAULT),
        .oMEM_REQ     (oMEM_REQ),
        .iMEM_BUSY    (iMEM_BUSY),
        .oMEM_RW      (oMEM_RW),
        .oMEM_ADDR    (oMEM_ADDR),
        .oMEM_MASK    (oMEM_MASK),
        .oMEM_DATA    (oMEM_DATA),
        .iMEM_VALID   (iMEM_VALID),
        .iMEM_DATA    (iMEM_DATA)
    );

    initial iCLOCK = 1'b0;
    always #5 iCLOCK = ~iCLOCK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge iCLOCK);
        #1;
    endtask

    // Present a request, confirm it is not refused, and clock it in.
    task automatic do_req(input logic rw, input logic [1:0] order, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] data);
        iCORE_REQ    = 1'b1;
        iCORE_RW     = rw;
        iCORE_ORDER  = order;
        iCORE_SIGNED = sgn;
        iCORE_ADDR   = addr;
        iCORE_DATA   = data;
        #1;
        check("req_not_busy", 32'(oCORE_BUSY), 32'd0);
        tick();
        iCORE_REQ = 1'b0;
    endtask

    // Return one word from memory. The response registers update on this edge.
    task automatic mem_ret(input logic [31:0] data);
        iMEM_VALID = 1'b1;
        iMEM_DATA  = data;
        tick();
        iMEM_VALID = 1'b0;
    endtask

    initial begin
        checks_cnt   = 0;
        errors_cnt   = 0;
        iRESET       = 1'b1;
        iRESET_SYNC  = 1'b0;
        iCORE_REQ    = 1'b0;
        iCORE_RW     = 1'b0;
        iCORE_ORDER  = 2'd0;
        iCORE_SIGNED = 1'b0;
        iCORE_ADDR   = '0;
        iCORE_DATA   = '0;
        iMEM_BUSY    = 1'b0;
        iMEM_VALID   = 1'b0;
        iMEM_DATA    = '0;

        // ---- reset state ----
        #1;
        check("rst_mem_req",    32'(oMEM_REQ), 32'd0);
        check("rst_core_valid", 32'(oCORE_VALID), 32'd0);
        check("rst_core_data",  oCORE_DATA, 32'd0);
        check("rst_mem_addr",   oMEM_ADDR, 32'd0);
        check("rst_mem_mask",   32'(oMEM_MASK), 32'd0);
        check("rst_busy",       32'(oCORE_BUSY), 32'd0);
        tick();
        tick();
        iRESET = 1'b0;
        tick();

        // ---- store byte a=0x1003 ----
        do_req(1'b1, 2'd0, 1'b0, 32'h0000_1003, 32'h0000_00AB);
        check("sb_req",  32'(oMEM_REQ), 32'd1);
        check("sb_rw",   32'(oMEM_RW), 32'd1);
        check("sb_addr", oMEM_ADDR, 32'h0000_1000);
        check("sb_mask", 32'(oMEM_MASK), 32'h8);
        check("sb_data", oMEM_DATA, 32'hAB00_0000);
        tick();
        check("sb_req_drop", 32'(oMEM_REQ), 32'd0);

        // ---- store half a=0x2002 ----
        do_req(1'b1, 2'd1, 1'b0, 32'h0000_2002, 32'h1234_5678);
        check("sh_mask", 32'(oMEM_MASK), 32'hC);
        check("sh_data", oMEM_DATA, 32'h5678_0000);

        // ---- load half signed a=0x2002 ----
        do_req(1'b0, 2'd1, 1'b1, 32'h0000_2002, 32'h0);
        check("lh_rw",   32'(oMEM_RW), 32'd0);
        check("lh_addr", oMEM_ADDR, 32'h0000_2000);
        check("lh_mask", 32'(oMEM_MASK), 32'hC);
        check("lh_valid_before", 32'(oCORE_VALID), 32'd0);
        mem_ret(32'h8001_1234);
        check("lh_valid", 32'(oCORE_VALID), 32'd1);
        check("lh_data",  oCORE_DATA, 32'hFFFF_8001);
        tick();
        check("lh_valid_pulse", 32'(oCORE_VALID), 32'd0);

        // ---- load byte unsigned / signed, word (order 3) ----
        do_req(1'b0, 2'd0, 1'b0, 32'h0000_5001, 32'h0);
        mem_ret(32'h1234_5678);
        check("lbu_data", oCORE_DATA, 32'h0000_0056);
        do_req(1'b0, 2'd0, 1'b1, 32'h0000_5003, 32'h0);
        mem_ret(32'h80FF_0000);
        check("lb_data", oCORE_DATA, 32'hFFFF_FF80);
        do_req(1'b0, 2'd3, 1'b1, 32'h0000_6000, 32'h0);
        check("lw3_mask", 32'(oMEM_MASK), 32'hF);
        mem_ret(32'h89AB_CDEF);
        check("lw3_data", oCORE_DATA, 32'h89AB_CDEF);

        // ---- fill the LDQ with 4 byte loads ----
        for (int i = 0; i < 4; i++) begin
            do_req(1'b0, 2'd0, 1'b0, 32'h0000_0010 + 32'(i), 32'h0);
        end
        iCORE_REQ   = 1'b1;
        iCORE_RW    = 1'b0;
        iCORE_ORDER = 2'd0;
        iCORE_ADDR  = 32'h0000_0014;
        #1;
        check("full_load_busy", 32'(oCORE_BUSY), 32'd1);
        iCORE_REQ = 1'b0;
        do_req(1'b1, 2'd0, 1'b0, 32'h0000_0050, 32'h0000_0077);
        check("full_store_rw",   32'(oMEM_RW), 32'd1);
        check("full_store_mask", 32'(oMEM_MASK), 32'h1);
        check("full_store_data", oMEM_DATA, 32'h0000_0077);

        // ---- pop one, then push and pop in the same cycle ----
        mem_ret(32'h4433_2211);
        check("pop0_data", oCORE_DATA, 32'h0000_0011);
        iMEM_VALID = 1'b1;
        iMEM_DATA  = 32'h4433_2211;
        do_req(1'b0, 2'd0, 1'b0, 32'h0000_0020, 32'h0);
        iMEM_VALID = 1'b0;
        check("pushpop_valid", 32'(oCORE_VALID), 32'd1);
        check("pushpop_data",  oCORE_DATA, 32'h0000_0022);
        do_req(1'b0, 2'd0, 1'b0, 32'h0000_0021, 32'h0);
        iCORE_REQ  = 1'b1;
        iCORE_RW   = 1'b0;
        iCORE_ADDR = 32'h0000_0022;
        #1;
        check("pushpop_full_busy", 32'(oCORE_BUSY), 32'd1);
        iCORE_REQ = 1'b0;
        mem_ret(32'h4433_2211);
        check("drain0", oCORE_DATA, 32'h0000_0033);
        mem_ret(32'h4433_2211);
        check("drain1", oCORE_DATA, 32'h0000_0044);
        mem_ret(32'h4433_2211);
        check("drain2", oCORE_DATA, 32'h0000_0011);
        mem_ret(32'h4433_2211);
        check("drain3", oCORE_DATA, 32'h0000_0022);
        mem_ret(32'hDEAD_0000);
        check("empty_ret_valid", 32'(oCORE_VALID), 32'd0);
        check("empty_ret_data",  oCORE_DATA, 32'h0000_0022);

        // ---- memory stall for 3 cycles ----
        do_req(1'b1, 2'd2, 1'b0, 32'h0000_4000, 32'hDEAD_BEEF);
        iMEM_BUSY   = 1'b1;
        iCORE_REQ   = 1'b1;
        iCORE_RW    = 1'b1;
        iCORE_ORDER = 2'd2;
        iCORE_ADDR  = 32'h0000_4004;
        iCORE_DATA  = 32'h1111_1111;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_busy", 32'(oCORE_BUSY), 32'd1);
            tick();
            check("stall_req",  32'(oMEM_REQ), 32'd1);
            check("stall_addr", oMEM_ADDR, 32'h0000_4000);
            check("stall_data", oMEM_DATA, 32'hDEAD_BEEF);
        end
        iMEM_BUSY = 1'b0;
        #1;
        check("unstall_busy", 32'(oCORE_BUSY), 32'd0);
        tick();
        iCORE_REQ = 1'b0;
        check("unstall_addr", oMEM_ADDR, 32'h0000_4004);
        check("unstall_data", oMEM_DATA, 32'h1111_1111);
        tick();
        check("unstall_req_drop", 32'(oMEM_REQ), 32'd0);

        // ---- misaligned word load a=0x3001 ----
        do_req(1'b0, 2'd2, 1'b0, 32'h0000_3001, 32'h0);
`ifdef LSU_ALIGNER_ALIGN_FAULT_EN
        check("mis_fault", 32'(oCORE_FAULT), 32'd1);
        check("mis_req",   32'(oMEM_REQ), 32'd0);
        tick();
        check("mis_fault_pulse", 32'(oCORE_FAULT), 32'd0);
        mem_ret(32'hCAFE_F00D);
        check("mis_no_push", 32'(oCORE_VALID), 32'd0);
`else
        check("mis_fault", 32'(oCORE_FAULT), 32'd0);
        check("mis_addr",  oMEM_ADDR, 32'h0000_3000);
        check("mis_mask",  32'(oMEM_MASK), 32'hF);
        mem_ret(32'hCAFE_F00D);
        check("mis_data",  oCORE_DATA, 32'hCAFE_F00D);
`endif

        // ---- asynchronous reset with 2 loads outstanding ----
        do_req(1'b0, 2'd0, 1'b0, 32'h0000_7000, 32'h0);
        do_req(1'b0, 2'd0, 1'b0, 32'h0000_7001, 32'h0);
        #2;
        iRESET = 1'b1;
        #1;
        check("arst_req",  32'(oMEM_REQ), 32'd0);
        check("arst_addr", oMEM_ADDR, 32'd0);
        check("arst_data", oCORE_DATA, 32'd0);
        tick();
        iRESET = 1'b0;
        mem_ret(32'h1234_5678);
        check("arst_no_valid", 32'(oCORE_VALID), 32'd0);

        // ---- synchronous clear with 2 loads outstanding ----
        do_req(1'b0, 2'd0, 1'b0, 32'h0000_7002, 32'h0);
        do_req(1'b0, 2'd0, 1'b0, 32'h0000_7003, 32'h0);
        iRESET_SYNC = 1'b1;
        tick();
        iRESET_SYNC = 1'b0;
        check("srst_req",  32'(oMEM_REQ), 32'd0);
        check("srst_mask", 32'(oMEM_MASK), 32'd0);
        mem_ret(32'h1234_5678);
        check("srst_no_valid", 32'(oCORE_VALID), 32'd0);

        // The LDQ must work normally after the clear.
        do_req(1'b0, 2'd0, 1'b0, 32'h0000_7002, 32'h0);
        mem_ret(32'h1234_5678);
        check("post_rst_data", oCORE_DATA, 32'h0000_0034);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
